stopwatch_ctrl: RTL and testbench

Stopwatch controller fed by the two-key debouncer's one-cycle `key_pulse` outputs. It counts elapsed time in centiseconds as four BCD digits, SS.cc from 00.00 to 59.99. Two keys select start/stop and lap/clear. The 16-bit BCD output feeds the seven-segment scan driver directly.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/stopwatch_ctrl_if.sv | 21 ++
 rtl/bcd_digit_cnt.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 98 +++++++++
 tb/tb_stopwatch_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types, digit limits and key indices for the stopwatch
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_t;

  localparam logic [3:0] BCD_MAX_9 = 4'd9;
  localparam logic [3:0] BCD_MAX_5 = 4'd5;

  localparam int KEY_SS = 0;
  localparam int KEY_LC = 1;

  // Terminal value is matched exactly so a digit can never leave its BCD range
  function automatic logic [3:0] bcd_next(input logic [3:0] q, input logic inc,
                                          input logic [3:0] max);
    if (!inc)
      return q;
    else if (q == max)
      return 4'd0;
    else
      return q + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - key events in, BCD time and status out
interface stopwatch_ctrl_if;
  logic [1:0]  key_pulse;
  logic [15:0] time_bcd;
  logic        running;
  logic        lap_active;

  modport master (
    output key_pulse,
    input  time_bcd,
    input  running,
    input  lap_active
  );

  modport slave (
    input  key_pulse,
    output time_bcd,
    output running,
    output lap_active
  );
endinterface

// File: rtl/bcd_digit_cnt.sv
// rtl/bcd_digit_cnt.sv - one BCD digit counting 0..MAX with carry out
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      q <= 4'd0;
    else
      q <= bcd_next(q, inc, MAX);
  end

  assign carry = inc && (q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - SS.cc stopwatch with start/stop and lap/clear keys
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  sw
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("stopwatch_ctrl: CLK_HZ / TICK_HZ must be at least 2");
    end
  endgenerate

  sw_state_t       state, state_nxt;
  logic [PW-1:0]   presc;
  logic [15:0]     lap_q;
  logic            k_ss, k_lc;
  logic            adv, tick, clr, lap_load;
  logic [3:0]      q0, q1, q2, q3;
  logic            c0, c1, c2, c3;

  assign k_ss = sw.key_pulse[KEY_SS];
  assign k_lc = sw.key_pulse[KEY_LC];

  // A stop press suppresses the tick on its own edge and freezes the prescaler
  assign adv  = ((state == RUN) || (state == LAP)) && !k_ss;
  assign tick = adv && (presc == PRESC_LAST);

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    lap_load  = 1'b0;
    unique case (state)
      IDLE: if (k_ss) state_nxt = RUN;
      RUN: begin
        if (k_ss) begin
          state_nxt = STOP;
        end else if (k_lc) begin
          state_nxt = LAP;
          lap_load  = 1'b1;
        end
      end
      LAP: begin
        if (k_ss)      state_nxt = STOP;
        else if (k_lc) state_nxt = RUN;
      end
      STOP: begin
        if (k_ss) begin
          state_nxt = RUN;
        end else if (k_lc) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      lap_q <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (clr)
        presc <= '0;
      else if (adv)
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      // Lap captures the post-tick count of this edge
      if (lap_load)
        lap_q <= {bcd_next(q3, c2, BCD_MAX_5), bcd_next(q2, c1, BCD_MAX_9),
                  bcd_next(q1, c0, BCD_MAX_9), bcd_next(q0, tick, BCD_MAX_9)};
    end
  end

  bcd_digit_cnt #(.MAX(BCD_MAX_9)) u_cs_ones  (.clk(clk), .rst(rst), .clr(clr), .inc(tick), .q(q0), .carry(c0));
  bcd_digit_cnt #(.MAX(BCD_MAX_9)) u_cs_tens  (.clk(clk), .rst(rst), .clr(clr), .inc(c0),   .q(q1), .carry(c1));
  bcd_digit_cnt #(.MAX(BCD_MAX_9)) u_sec_ones (.clk(clk), .rst(rst), .clr(clr), .inc(c1),   .q(q2), .carry(c2));
  bcd_digit_cnt #(.MAX(BCD_MAX_5)) u_sec_tens (.clk(clk), .rst(rst), .clr(clr), .inc(c2),   .q(q3), .carry(c3));

  logic unused_carry;
  assign unused_carry = c3;

  assign sw.time_bcd   = (state == LAP) ? lap_q : {q3, q2, q1, q0};
  assign sw.running    = (state == RUN) || (state == LAP);
  assign sw.lap_active = (state == LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1ns after an edge; the key is sampled at the next edge
  task automatic pulse(input logic [1:0] k);
    sw_if.key_pulse = k;
    @(posedge clk);
    #1;
    sw_if.key_pulse = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] t, input logic r, input logic l);
    n_cmp++;
    if (sw_if.time_bcd !== t || sw_if.running !== r || sw_if.lap_active !== l) begin
      n_fail++;
      $display("FAIL %s: got time=%h running=%b lap=%b, want time=%h running=%b lap=%b",
               name, sw_if.time_bcd, sw_if.running, sw_if.lap_active, t, r, l);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw_if.key_pulse = 2'b01;
    wait_cycles(2);
    chk("reset_prio", 16'h0000, 1'b0, 1'b0);
    sw_if.key_pulse = 2'b00;
    rst = 1'b0;
    wait_cycles(1);
    chk("reset_state", 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_start_wrap();
    do_reset();
    pulse(2'b01);
    chk("start_running", 16'h0000, 1'b1, 1'b0);
    wait_cycles(9);
    chk("before_first_tick", 16'h0000, 1'b1, 1'b0);
    wait_cycles(1);
    chk("first_tick", 16'h0001, 1'b1, 1'b0);
    wait_cycles(990);
    chk("one_second", 16'h0100, 1'b1, 1'b0);
    wait_cycles(58980);
    chk("tick_5998", 16'h5998, 1'b1, 1'b0);
    wait_cycles(10);
    chk("tick_5999", 16'h5999, 1'b1, 1'b0);
    wait_cycles(10);
    chk("wrap_6000", 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_lap();
    do_reset();
    pulse(2'b01);
    wait_cycles(1230);
    chk("lap_pre", 16'h0123, 1'b1, 1'b0);
    pulse(2'b10);
    chk("lap_enter", 16'h0123, 1'b1, 1'b1);
    wait_cycles(50);
    chk("lap_frozen", 16'h0123, 1'b1, 1'b1);
    pulse(2'b10);
    chk("lap_exit_live", 16'h0128, 1'b1, 1'b0);
  endtask

  task automatic test_lap_tick();
    do_reset();
    pulse(2'b01);
    wait_cycles(9);
    pulse(2'b10);
    chk("lap_on_tick", 16'h0001, 1'b1, 1'b1);
    wait_cycles(30);
    chk("lap_on_tick_hold", 16'h0001, 1'b1, 1'b1);
    pulse(2'b01);
    chk("lap_to_stop_live", 16'h0004, 1'b0, 1'b0);
  endtask

  task automatic test_stop_resume_clear();
    do_reset();
    pulse(2'b01);
    wait_cycles(423);
    chk("stop_pre", 16'h0042, 1'b1, 1'b0);
    pulse(2'b01);
    chk("stop_enter", 16'h0042, 1'b0, 1'b0);
    wait_cycles(100);
    chk("stop_hold", 16'h0042, 1'b0, 1'b0);
    pulse(2'b01);
    wait_cycles(6);
    chk("resume_partial_pre", 16'h0042, 1'b1, 1'b0);
    wait_cycles(1);
    chk("resume_partial_tick", 16'h0043, 1'b1, 1'b0);
    pulse(2'b01);
    chk("stop_again", 16'h0043, 1'b0, 1'b0);
    pulse(2'b10);
    chk("clear_idle", 16'h0000, 1'b0, 1'b0);
    wait_cycles(20);
    chk("idle_no_count", 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_stop_on_tick();
    do_reset();
    pulse(2'b01);
    wait_cycles(9);
    pulse(2'b01);
    chk("stop_suppresses_tick", 16'h0000, 1'b0, 1'b0);
    pulse(2'b01);
    chk("resume_at_last", 16'h0000, 1'b1, 1'b0);
    wait_cycles(1);
    chk("resume_tick_next", 16'h0001, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(2'b01);
    wait_cycles(5);
    pulse(2'b11);
    chk("both_keys_stop", 16'h0000, 1'b0, 1'b0);
    do_reset();
    pulse(2'b10);
    chk("idle_k1_ignored", 16'h0000, 1'b0, 1'b0);
    wait_cycles(20);
    chk("idle_k1_still", 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_lap();
    do_reset();
    pulse(2'b01);
    wait_cycles(25);
    pulse(2'b10);
    chk("mid_lap_enter", 16'h0002, 1'b1, 1'b1);
    rst = 1'b1;
    wait_cycles(1);
    chk("mid_lap_reset", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    pulse(2'b10);
    wait_cycles(30);
    chk("post_reset_k1", 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    sw_if.key_pulse = 2'b00;
    test_reset();
    test_start_wrap();
    test_lap();
    test_lap_tick();
    test_stop_resume_clear();
    test_stop_on_tick();
    test_simultaneous();
    test_reset_mid_lap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
